mdu_sequencer: RTL

Multi-cycle multiply/divide sequencer for the CPU execute stage. It sits beside the single-cycle ALU and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU requests from the decode/control path and runs an iterative shift-add multiply or restoring divide, one bit per cycle. It reports busy/done so the pipeline control can stall dependent mfhi/mflo instructions.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mdu_step.sv | 17 +
 rtl/mdu_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared execute-stage constants for the multiply/divide unit
package cpu_pkg;
  localparam int MDU_XLEN = 32;
  localparam logic [1:0] MDU_OP_MULT  = 2'b00;
  localparam logic [1:0] MDU_OP_MULTU = 2'b01;
  localparam logic [1:0] MDU_OP_DIV   = 2'b10;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b11;
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t MDU_IDLE = 2'd0;
  localparam mdu_state_t MDU_CALC = 2'd1;
  localparam mdu_state_t MDU_FIX  = 2'd2;
  localparam mdu_state_t MDU_DONE = 2'd3;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one shift-add multiply or restoring-divide iteration on the accumulator
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   b,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);
  logic [XLEN:0] sum, trial;
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b : {XLEN{1'b0}})};
    trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b};
    acc_next = is_div ? (trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                      : {sum, acc[XLEN-1:1]};
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative signed/unsigned multiply/divide owning the HI/LO pair
module mdu_sequencer
  import cpu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);
  mdu_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic div_q, sa, sb, sgn, idle, accept, dz;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic [XLEN-1:0] b, fix_hi, fix_lo;

  mdu_step #(.XLEN(XLEN)) u_step (.acc(acc), .b(b), .is_div(div_q), .acc_next(acc_next));

  always_comb begin
    sgn = !op[0];
    idle = state == MDU_IDLE || state == MDU_DONE;
    accept = idle && start && !flush;
    dz = op[1] && rs2 == '0;
    nxt = flush ? MDU_IDLE
        : accept ? (dz ? MDU_DONE : MDU_CALC)
        : state == MDU_CALC ? (cnt == CW'(XLEN-1) ? MDU_FIX : MDU_CALC)
        : state == MDU_FIX ? MDU_DONE : MDU_IDLE;
    prod = (sa ^ sb) ? -acc : acc;
    // remainder follows the dividend's sign, quotient the xor of both
    fix_hi = div_q ? (sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN]) : prod[2*XLEN-1:XLEN];
    fix_lo = div_q ? ((sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0]) : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= MDU_IDLE;
      cnt <= '0;
      div_q <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      acc <= '0;
      b <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt == MDU_CALC || nxt == MDU_FIX;
      done <= nxt == MDU_DONE;
      div_zero <= accept && dz;
      cnt <= accept ? '0 : cnt + 1'b1;
      if (accept) begin
        div_q <= op[1];
        sa <= sgn && rs1[XLEN-1];
        sb <= sgn && rs2[XLEN-1];
        acc <= {{XLEN{1'b0}}, ((sgn && rs1[XLEN-1]) ? -rs1 : rs1)};
        b <= (sgn && rs2[XLEN-1]) ? -rs2 : rs2;
      end else if (state == MDU_CALC) begin
        acc <= acc_next;
      end
      if (!busy && wr_hi) hi <= rs1;
      if (!busy && wr_lo) lo <= rs1;
      if (state == MDU_FIX && !flush) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
endmodule
